key_accumulator: RTL and testbench

Hardware replacement for the software accumulate loop on the DE2 board. It takes raw active-low pushbuttons for clear and accumulate plus the switch bank, and debounces and edge-detects both buttons. On each accepted press it adds or subtracts the switch value into a WIDTH-bit register, in either wrap or saturate mode. It sits in the top level between the KEY/S pins and the LEDG driver, beside the Nios II system, and exposes a sticky overflow flag and an event counter.

---
 rtl/key_accumulator_if.sv | 27 ++
 rtl/key_accumulator.sv | 168 ++++++++++++++++
 tb/tb_key_accumulator.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_accumulator_if.sv
// Pushbutton/switch inputs and accumulator outputs of key_accumulator.
// master: board-side driver of the raw buttons and switches.
// slave:  the accumulator itself.
interface key_accumulator_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 8
);
    logic               clear_n;
    logic               accum_n;
    logic [WIDTH-1:0]   sw;
    logic               mode_sub;
    logic               mode_sat;
    logic [WIDTH-1:0]   sum;
    logic               overflow;
    logic [COUNT_W-1:0] event_count;
    logic               accum_ack;

    modport master (
        output clear_n, accum_n, sw, mode_sub, mode_sat,
        input  sum, overflow, event_count, accum_ack
    );

    modport slave (
        input  clear_n, accum_n, sw, mode_sub, mode_sat,
        output sum, overflow, event_count, accum_ack
    );
endinterface

// File: rtl/key_accumulator.sv
// Debounced pushbutton accumulator: two active-low buttons (clear, accumulate)
// are synchronized, debounced and press-detected; each accepted accumulate
// press adds or subtracts the switch value in wrap or saturate mode.

// Per-button synchronizer, debouncer and press detector.
// The debounce timer is a down-counter: it reloads to DEBOUNCE_CYCLES-1
// whenever the synchronized level agrees with the debounced level, and the
// level change is accepted when a mismatch is seen with the timer at zero.
// That accepts a change after exactly DEBOUNCE_CYCLES consecutive mismatching
// samples, the same as counting up to DEBOUNCE_CYCLES-1.
module key_accumulator_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_sys_i,
    input  logic rst_i,
    input  logic raw_n_i,
    output logic press_o
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             db_q;
    logic             db_d;
    logic             db_dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Two-flop synchronizer; released (1) after reset.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= raw_n_i;
            s2_q <= s1_q;
        end
    end

    // Debounce timer: count down while the synchronized level disagrees.
    always_comb begin
        db_d  = db_q;
        cnt_d = RELOAD;
        if (s2_q != db_q) begin
            if (cnt_q == '0) begin
                db_d  = s2_q;
                cnt_d = RELOAD;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Debounced level, timer and one-cycle delayed level for edge detect.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            db_q     <= 1'b1;
            cnt_q    <= RELOAD;
            db_dly_q <= 1'b1;
        end else begin
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            db_dly_q <= db_q;
        end
    end

    // Falling edge of the debounced level is a press; release is ignored.
    assign press_o = ~db_q & db_dly_q;
endmodule

module key_accumulator #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COUNT_W         = 8
) (
    input  logic                clk_sys_i,
    input  logic                rst_i,
    key_accumulator_if.slave    bus
);
    logic               clear_evt;
    logic               accum_evt;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_d;
    logic               ovf_q;
    logic               ovf_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               ack_q;
    logic               ack_d;
    logic [WIDTH:0]     add_r;
    logic [WIDTH:0]     sub_r;

    key_accumulator_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_clear (
        .clk_sys_i (clk_sys_i),
        .rst_i     (rst_i),
        .raw_n_i   (bus.clear_n),
        .press_o   (clear_evt)
    );

    key_accumulator_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_accum (
        .clk_sys_i (clk_sys_i),
        .rst_i     (rst_i),
        .raw_n_i   (bus.accum_n),
        .press_o   (accum_evt)
    );

    // One extra bit holds the carry (add) or borrow (sub).
    assign add_r = {1'b0, sum_q} + {1'b0, bus.sw};
    assign sub_r = {1'b0, sum_q} - {1'b0, bus.sw};

    // Next accumulator state; clear takes priority and drops a coincident accumulate.
    always_comb begin
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        ack_d   = 1'b0;
        if (clear_evt) begin
            sum_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
        end else if (accum_evt) begin
            ack_d   = 1'b1;
            count_d = count_q + 1'b1;
            if (!bus.mode_sub) begin
                sum_d = add_r[WIDTH-1:0];
                if (add_r[WIDTH]) begin
                    ovf_d = 1'b1;
                    if (bus.mode_sat) begin
                        sum_d = '1;
                    end
                end
            end else begin
                sum_d = sub_r[WIDTH-1:0];
                if (sub_r[WIDTH]) begin
                    ovf_d = 1'b1;
                    if (bus.mode_sat) begin
                        sum_d = '0;
                    end
                end
            end
        end
    end

    // Registered accumulator, sticky overflow, event counter and ack pulse.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.sum         = sum_q;
    assign bus.overflow    = ovf_q;
    assign bus.event_count = count_q;
    assign bus.accum_ack   = ack_q;
endmodule

// File: tb/tb_key_accumulator.sv
// Scoreboard bench for key_accumulator with a short debounce window.
module tb_key_accumulator;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_accumulator_if #(.WIDTH(W), .COUNT_W(CW)) bus ();

    key_accumulator #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .COUNT_W         (CW)
    ) dut (
        .clk_sys_i (clk),
        .rst_i     (rst),
        .bus       (bus)
    );

    typedef struct {
        int sum;
        int ovf;
        int cnt;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_sum  = 0;
    int   m_ovf  = 0;
    int   m_cnt  = 0;

    always @(posedge clk) cyc++;

    // Reference model: plain integer arithmetic on the accumulator rules.
    task automatic model_accum(input int sw, input bit sub, input bit sat);
        int r;
        r = sub ? (m_sum - sw) : (m_sum + sw);
        if (r > (2**W - 1)) begin
            m_ovf = 1;
            m_sum = sat ? (2**W - 1) : (r - 2**W);
        end else if (r < 0) begin
            m_ovf = 1;
            m_sum = sat ? 0 : (r + 2**W);
        end else begin
            m_sum = r;
        end
        m_cnt = (m_cnt + 1) % (2**CW);
    endtask

    task automatic model_clear();
        m_sum = 0;
        m_ovf = 0;
        m_cnt = 0;
    endtask

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_state(input string name);
        check({name, "_sum"}, int'(bus.sum), m_sum);
        check({name, "_ovf"}, int'(bus.overflow), m_ovf);
        check({name, "_cnt"}, int'(bus.event_count), m_cnt);
    endtask

    // Monitor: every ack must match the oldest expected accumulate.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.accum_ack === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_ack: ack at cycle %0d sum=%0h with no event expected", cyc, bus.sum);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(bus.sum) != e.sum || int'(bus.overflow) != e.ovf ||
                        int'(bus.event_count) != e.cnt || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL accum_event: got sum=%0h ovf=%0d cnt=%0d cyc=%0d, expected sum=%0h ovf=%0d cnt=%0d cyc=%0d",
                                 bus.sum, bus.overflow, bus.event_count, cyc, e.sum, e.ovf, e.cnt, e.cyc);
                    end
                end
            end
        end
    end

    task automatic garble();
        bus.sw       = W'($urandom);
        bus.mode_sub = 1'($urandom);
        bus.mode_sat = 1'($urandom);
    endtask

    // Hold the selected raw button(s) low for n cycles. Real operands are
    // valid only around the event edge (edge 7); garbage elsewhere.
    task automatic press(input bit acc, input bit clr, input int n,
                         input int sw, input bit sub, input bit sat);
        int c0;
        int last;
        bit accept;
        @(posedge clk);
        #1;
        c0     = cyc;
        accept = (n >= D);
        garble();
        if (acc) bus.accum_n = 1'b0;
        if (clr) bus.clear_n = 1'b0;
        if (accept) begin
            if (clr) begin
                model_clear();
            end else if (acc) begin
                model_accum(sw, sub, sat);
                exp_q.push_back('{m_sum, m_ovf, m_cnt, c0 + 7});
            end
        end
        last = (n > 8) ? n : 8;
        for (int i = 1; i <= last; i++) begin
            @(posedge clk);
            #1;
            if (i == n) begin
                bus.accum_n = 1'b1;
                bus.clear_n = 1'b1;
            end
            if (i == 6) begin
                bus.sw       = W'(sw);
                bus.mode_sub = sub;
                bus.mode_sat = sat;
            end
            if (i == 7) begin
                garble();
                if (clr && accept) check_state("clear_edge7");
            end
        end
        repeat (D + 4) @(posedge clk);
        #1;
    endtask

    task automatic add(input int sw, input bit sat);
        press(1'b1, 1'b0, 10, sw, 1'b0, sat);
    endtask

    task automatic sub(input int sw, input bit sat);
        press(1'b1, 1'b0, 10, sw, 1'b1, sat);
    endtask

    task automatic clear();
        press(1'b0, 1'b1, 10, 0, 1'b0, 1'b0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d expected events pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int c0;
        bus.clear_n  = 1'b1;
        bus.accum_n  = 1'b1;
        bus.sw       = '0;
        bus.mode_sub = 1'b0;
        bus.mode_sat = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sum", int'(bus.sum), 0);
        check("reset_ovf", int'(bus.overflow), 0);
        check("reset_cnt", int'(bus.event_count), 0);
        check("reset_ack", int'(bus.accum_ack), 0);
        rst = 1'b0;
        model_clear();

        // First press, then a long hold that must not repeat.
        add(8'h05, 1'b0);
        check("first_sum", int'(bus.sum), 8'h05);
        check("first_cnt", int'(bus.event_count), 1);
        press(1'b1, 1'b0, 20, 8'h01, 1'b0, 1'b0);

        // Short pulse filtered; exactly D samples accepted.
        press(1'b1, 1'b0, D - 1, 8'h33, 1'b0, 1'b0);
        check_state("filtered");
        press(1'b1, 1'b0, D, 8'h01, 1'b0, 1'b0);

        // Wrap add with sticky overflow.
        clear();
        check_state("after_clear");
        add(8'hF0, 1'b0);
        add(8'h20, 1'b0);
        check("wrap_sum", int'(bus.sum), 8'h10);
        check("wrap_ovf", int'(bus.overflow), 1);
        add(8'h01, 1'b0);
        check("sticky_sum", int'(bus.sum), 8'h11);
        check("sticky_ovf", int'(bus.overflow), 1);

        // Saturating add and subtract, wrapping subtract.
        clear();
        add(8'hF0, 1'b1);
        add(8'h20, 1'b1);
        check("sat_add_sum", int'(bus.sum), 8'hFF);
        check("sat_add_ovf", int'(bus.overflow), 1);
        clear();
        add(8'h10, 1'b1);
        sub(8'h20, 1'b1);
        check("sat_sub_sum", int'(bus.sum), 8'h00);
        check("sat_sub_ovf", int'(bus.overflow), 1);
        clear();
        add(8'h10, 1'b0);
        sub(8'h20, 1'b0);
        check("wrap_sub_sum", int'(bus.sum), 8'hF0);
        check("wrap_sub_ovf", int'(bus.overflow), 1);

        // Simultaneous clear and accumulate: clear wins, no ack.
        press(1'b1, 1'b1, 10, 8'h55, 1'b0, 1'b0);
        check_state("simul");

        // Reset two cycles into a press, button still held afterwards.
        add(8'h07, 1'b0);
        @(posedge clk);
        #1;
        bus.sw       = 8'h09;
        bus.mode_sub = 1'b0;
        bus.mode_sat = 1'b0;
        bus.accum_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_sum", int'(bus.sum), 0);
        check("rst_mid_ovf", int'(bus.overflow), 0);
        check("rst_mid_cnt", int'(bus.event_count), 0);
        check("rst_mid_ack", int'(bus.accum_ack), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        c0  = cyc;
        model_clear();
        model_accum(8'h09, 1'b0, 1'b0);
        exp_q.push_back('{m_sum, m_ovf, m_cnt, c0 + 7});
        repeat (12) @(posedge clk);
        #1;
        bus.accum_n = 1'b1;
        repeat (D + 6) @(posedge clk);
        #1;
        check_state("after_rst_press");

        // Randomized mix of accumulates, filtered pulses and clears.
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                clear();
                check_state("rand_clear");
            end else if (kind == 1) begin
                press(1'b1, 1'b0, $urandom_range(1, D - 1), $urandom_range(0, 255), 1'b0, 1'b0);
            end else begin
                press(1'b1, 1'b0, $urandom_range(D, 14), $urandom_range(0, 255),
                      1'($urandom), 1'($urandom));
            end
        end

        repeat (20) @(posedge clk);
        #1;
        check("pending_events", exp_q.size(), 0);
        check_state("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
